// File: rtl/next186_pkg.sv
// next186 shared definitions: SRAM address width,
// ioctl image indices and the loader state encoding.
package next186_pkg;

   localparam int ADDR_W = 21;

   localparam logic [7:0] IDX_BIOS = 8'h00;
   localparam logic [7:0] IDX_RAM  = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD
   } ld_state_e;

endpackage

// File: rtl/ioctl_byte_fifo.sv
// Small synchronous FIFO holding {sram address, byte}
// pairs between the ioctl strobe and the SRAM sequencer.
module ioctl_byte_fifo #(
   parameter int W     = 29,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW:0]   cnt_q;
   logic [PW:0]   cnt_d;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // a pop frees the slot, so push on full is fine alongside it
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);

   // storage array, contents need no reset
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ioctl_sram_loader.sv
// HPS ioctl download -> external byte SRAM writer with
// core bus passthrough and core reset hold-off.
module ioctl_sram_loader #(
   parameter int                 ADDR_W     = next186_pkg::ADDR_W,
   parameter int                 FIFO_DEPTH = 4,
   parameter int                 WE_CYCLES  = 2,
   parameter logic [ADDR_W-1:0]  BASE0      = 21'h1F0000,
   parameter logic [ADDR_W-1:0]  BASE1      = 21'h000000,
   parameter int                 POST_HOLD  = 16
) (
   input  logic              clk_28_636,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic              ioctl_wait,
   input  logic [ADDR_W-1:0] core_a,
   input  logic              core_we_n,
   input  logic [7:0]        core_dout,
   output logic [7:0]        core_din,
   output logic              core_reset,
   output logic              load_done,
   output logic              overflow,
   output logic [ADDR_W-1:0] SRAM_A,
   output logic              SRAM_WE_n,
   output logic [7:0]        sram_dout,
   output logic              sram_d_oe,
   input  logic [7:0]        sram_din
);

   import next186_pkg::*;

   localparam int FW = ADDR_W + 8;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = $clog2(WE_CYCLES + 1);
   localparam int HW = $clog2(POST_HOLD + 1);

   logic              sel_bios;
   logic              accept;
   logic              push_ok;
   logic              pop;
   logic              full;
   logic              empty;
   logic [PW:0]       count;
   logic [PW:0]       cnt_d;
   logic [ADDR_W-1:0] push_addr;
   logic [FW-1:0]     push_word;
   logic [FW-1:0]     pop_word;
   logic              busy;
   logic              own;
   logic              unused_addr_hi;

   ld_state_e         state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        data_q;
   logic              we_n_q;
   logic              oe_q;
   logic [WW-1:0]     pulse_q;
   logic              wait_q;
   logic              ovf_q;
   logic              done_q;
   logic              wrote_q;
   logic [HW-1:0]     hold_q;

   assign unused_addr_hi = ^ioctl_addr[24:ADDR_W];

   assign sel_bios  = (ioctl_index == IDX_BIOS);
   assign accept    = ioctl_wr && ioctl_download &&
                      (sel_bios || ioctl_index == IDX_RAM);
   assign push_addr = (sel_bios ? BASE0 : BASE1) +
                      ioctl_addr[ADDR_W-1:0];
   assign push_word = {push_addr, ioctl_dout};

   // the sequencer takes a new byte from IDLE or on its HOLD clock
   assign pop     = !empty &&
                    (state_q == ST_IDLE || state_q == ST_HOLD);
   assign push_ok = accept && (!full || pop);
   assign cnt_d   = count + CW'(push_ok) - CW'(pop);

   ioctl_byte_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_28_636),
      .rst_ni  (reset_n),
      .push_i  (push_ok),
      .pop_i   (pop),
      .wdata_i (push_word),
      .rdata_o (pop_word),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   // SRAM write sequencer: SETUP, WE_CYCLES of PULSE, HOLD
   always_ff @(posedge clk_28_636 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         we_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         pulse_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  state_q          <= ST_SETUP;
                  {addr_q, data_q} <= pop_word;
                  oe_q             <= 1'b1;
               end
            end
            ST_SETUP: begin
               state_q <= ST_PULSE;
               we_n_q  <= 1'b0;
               pulse_q <= WW'(WE_CYCLES - 1);
            end
            ST_PULSE: begin
               if (pulse_q == '0) begin
                  state_q <= ST_HOLD;
                  we_n_q  <= 1'b1;
               end else begin
                  pulse_q <= pulse_q - WW'(1);
               end
            end
            ST_HOLD: begin
               if (pop) begin
                  state_q          <= ST_SETUP;
                  {addr_q, data_q} <= pop_word;
               end else begin
                  state_q <= ST_IDLE;
                  oe_q    <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // backpressure from post-clock occupancy, sticky drop flag
   always_ff @(posedge clk_28_636 or negedge reset_n) begin
      if (!reset_n) begin
         wait_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         wait_q <= (cnt_d >= CW'(FIFO_DEPTH - 1));
         if (accept && !push_ok) ovf_q <= 1'b1;
      end
   end

   assign busy = ioctl_download || !empty || state_q != ST_IDLE;

   // core reset hold-off countdown and completion pulse
   always_ff @(posedge clk_28_636 or negedge reset_n) begin
      if (!reset_n) begin
         hold_q  <= HW'(POST_HOLD);
         wrote_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (busy) begin
            hold_q <= HW'(POST_HOLD);
         end else if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
         end
         if (state_q == ST_HOLD) begin
            wrote_q <= 1'b1;
         end else if (!busy && hold_q == HW'(1) && wrote_q) begin
            done_q  <= 1'b1;
            wrote_q <= 1'b0;
         end
      end
   end

   assign own        = ioctl_download || state_q != ST_IDLE;
   assign SRAM_A     = own ? addr_q : core_a;
   assign SRAM_WE_n  = own ? we_n_q : core_we_n;
   assign sram_dout  = own ? data_q : core_dout;
   assign sram_d_oe  = own ? oe_q   : ~core_we_n;
   assign core_din   = sram_din;
   assign core_reset = busy || hold_q != '0;
   assign ioctl_wait = wait_q;
   assign overflow   = ovf_q;
   assign load_done  = done_q;

endmodule

// File: tb/tb_ioctl_sram_loader.sv
// Bench for ioctl_sram_loader: directed downloads checked
// against a queue/phase model every cycle plus literal pins.
module tb_ioctl_sram_loader;

   localparam int DEPTH = 4;
   localparam int WC    = 2;
   localparam int PH    = 16;
   localparam logic [20:0] B0 = 21'h1F0000;
   localparam logic [20:0] B1 = 21'h000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic [7:0]  ioctl_index = '0;
   logic        ioctl_wait;
   logic [20:0] core_a = 21'h0ABCD;
   logic        core_we_n = 1'b1;
   logic [7:0]  core_dout = 8'h11;
   logic [7:0]  core_din;
   logic        core_reset;
   logic        load_done;
   logic        overflow;
   logic [20:0] SRAM_A;
   logic        SRAM_WE_n;
   logic [7:0]  sram_dout;
   logic        sram_d_oe;
   logic [7:0]  sram_din = 8'h77;

   always #5 clk = ~clk;

   ioctl_sram_loader #(
      .ADDR_W(21), .FIFO_DEPTH(DEPTH), .WE_CYCLES(WC),
      .BASE0(B0), .BASE1(B1), .POST_HOLD(PH)
   ) dut (
      .clk_28_636(clk), .reset_n(rst_n),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
      .core_a(core_a), .core_we_n(core_we_n),
      .core_dout(core_dout), .core_din(core_din),
      .core_reset(core_reset), .load_done(load_done),
      .overflow(overflow), .SRAM_A(SRAM_A),
      .SRAM_WE_n(SRAM_WE_n), .sram_dout(sram_dout),
      .sram_d_oe(sram_d_oe), .sram_din(sram_din)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [20:0] a;
      logic [7:0]  d;
   } ent_t;

   ent_t        mq[$];
   int          ph;
   logic [20:0] m_a;
   logic [7:0]  m_d;
   logic        m_ovf, m_wait, m_done;
   int          m_since;
   int          m_hc;
   logic [7:0]  mmem [logic [20:0]];

   initial begin
      bit   own, busy, acc, pp;
      ent_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mq.delete(); ph = 0; m_ovf = 0; m_wait = 0;
            m_done = 0; m_since = 0; m_hc = PH;
         end
         own  = ioctl_download || ph != 0;
         busy = ioctl_download || mq.size() != 0 || ph != 0;
         chk("we_n", 32'(SRAM_WE_n),
             32'(own ? !(ph >= 2 && ph <= WC + 1) : core_we_n));
         chk("d_oe", 32'(sram_d_oe),
             32'(own ? (ph >= 1) : !core_we_n));
         if (!own) begin
            chk("pass_a", 32'(SRAM_A), 32'(core_a));
            chk("pass_d", 32'(sram_dout), 32'(core_dout));
         end else if (ph >= 1) begin
            chk("wr_a", 32'(SRAM_A), 32'(m_a));
            chk("wr_d", 32'(sram_dout), 32'(m_d));
         end
         chk("wait", 32'(ioctl_wait), 32'(m_wait));
         chk("ovf", 32'(overflow), 32'(m_ovf));
         chk("core_reset", 32'(core_reset), 32'(busy || m_hc != 0));
         chk("load_done", 32'(load_done), 32'(m_done));
         chk("core_din", 32'(core_din), 32'(sram_din));
         if (rst_n) begin
            acc = ioctl_wr && ioctl_download && ioctl_index <= 8'd1;
            pp  = mq.size() != 0 && (ph == 0 || ph == WC + 2);
            if (ph == 2) mmem[m_a] = m_d;
            if (ph == WC + 2) m_since++;
            m_done = !busy && m_hc == 1 && m_since > 0;
            if (m_done) m_since = 0;
            if (busy) m_hc = PH;
            else if (m_hc > 0) m_hc--;
            if (pp) begin
               e = mq.pop_front(); m_a = e.a; m_d = e.d; ph = 1;
            end else if (ph == WC + 2) ph = 0;
            else if (ph > 0) ph++;
            if (acc) begin
               if (mq.size() < DEPTH) begin
                  e.a = (ioctl_index == 8'd0 ? B0 : B1) + ioctl_addr[20:0];
                  e.d = ioctl_dout;
                  mq.push_back(e);
               end else m_ovf = 1;
            end
            m_wait = mq.size() >= DEPTH - 1;
         end
      end
   end

   // ---------------- pin monitor ----------------
   logic [20:0] la[$];
   logic [7:0]  ld[$];
   int          lc[$];
   bit          log_en = 1;
   int          done_cnt = 0, done_cyc = -1, cr_fall = -1;

   initial begin
      logic prev_we, prev_cr;
      prev_we = 1; prev_cr = 1;
      forever begin
         @(negedge clk);
         if (log_en && prev_we === 1'b1 && SRAM_WE_n === 1'b0) begin
            la.push_back(SRAM_A); ld.push_back(sram_dout);
            lc.push_back(cyc);
         end
         if (load_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
         if (prev_cr === 1'b1 && core_reset === 1'b0) cr_fall = cyc;
         prev_we = SRAM_WE_n; prev_cr = core_reset;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] ix, input logic [24:0] a,
                       input logic [7:0] d);
      ioctl_wr = 1; ioctl_index = ix; ioctl_addr = a; ioctl_dout = d;
      tick();
      ioctl_wr = 0;
   endtask

   task automatic clr();
      la.delete(); ld.delete(); lc.delete();
      done_cnt = 0; done_cyc = -1; cr_fall = -1;
   endtask

   task automatic wait_log(input int n, input int budget);
      int k = 0;
      while (la.size() < n && k < budget) begin tick(); k++; end
      chk("wait_log_bound", 32'(la.size() >= n), 1);
   endtask

   initial begin
      int n, r, sent, k;
      bit saw_wait;
      #200000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int n, r, sent, k;
      bit saw_wait;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_we_n", 32'(SRAM_WE_n), 1);
      chk("rst_oe", 32'(sram_d_oe), 0);
      chk("rst_wait", 32'(ioctl_wait), 0);
      chk("rst_done", 32'(load_done), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_core_reset", 32'(core_reset), 1);
      tick();
      rst_n = 1; r = cyc;
      repeat (30) tick();
      chk("rst_release_hold", 32'(cr_fall - r), 16);
      chk("rst_no_done", 32'(done_cnt), 0);

      // single byte timing
      ioctl_download = 1; tick(); tick(); clr();
      n = cyc;
      send(8'h00, 25'h10, 8'hA5);
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk);
         chk($sformatf("t1_we_n_N+%0d", j), 32'(SRAM_WE_n),
             32'(!(j == 3 || j == 4)));
         chk($sformatf("t1_oe_N+%0d", j), 32'(sram_d_oe),
             32'(j >= 2 && j <= 5));
         if (j == 2) begin
            chk("t1_addr", 32'(SRAM_A), 32'h1F0010);
            chk("t1_data", 32'(sram_dout), 32'hA5);
         end
         tick();
      end
      chk("t1_fall_cycle", 32'(lc.size() > 0 ? lc[0] - n : -1), 3);

      // address wraps modulo 2^21
      send(8'h00, 25'h1100005, 8'h3C);
      wait_log(2, 20);
      if (la.size() >= 2) begin
         chk("wrap_addr", 32'(la[1]), 32'h0F0005);
         chk("wrap_data", 32'(ld[1]), 32'h3C);
      end
      repeat (6) tick();

      // burst that honours ioctl_wait
      clr(); sent = 0; saw_wait = 0; k = 0;
      while (sent < 8 && k < 100) begin
         if (ioctl_wait) begin saw_wait = 1; tick(); end
         else begin
            send(8'h01, 25'h100 + 25'(sent), 8'h80 + 8'(sent));
            sent++;
         end
         k++;
      end
      chk("t2_saw_wait", 32'(saw_wait), 1);
      wait_log(8, 100);
      for (int i = 0; i < 8 && i < la.size(); i++) begin
         chk($sformatf("t2_addr%0d", i), 32'(la[i]), 32'h100 + i);
         chk($sformatf("t2_data%0d", i), 32'(ld[i]), 32'h80 + i);
         if (i > 0) chk($sformatf("t2_gap%0d", i),
                        32'(lc[i] - lc[i-1]), 4);
      end
      chk("t2_no_ovf", 32'(overflow), 0);
      repeat (8) tick();

      // burst ignoring wait, download drops with bytes queued
      clr();
      for (int i = 0; i < 8; i++)
         send(8'h01, 25'h200 + 25'(i), 8'h40 + 8'(i));
      ioctl_download = 0;
      wait_log(6, 60);
      repeat (30) tick();
      chk("t3_ovf", 32'(overflow), 1);
      chk("t3_count", 32'(la.size()), 6);
      for (int i = 0; i < 6 && i < la.size(); i++)
         chk($sformatf("t3_addr%0d", i), 32'(la[i]), 32'h200 + i);
      chk("t3_model_drop6", 32'(mmem.exists(21'h206)), 0);
      chk("t3_model_drop7", 32'(mmem.exists(21'h207)), 0);
      chk("t3_model_last", 32'(mmem.exists(21'h205) ?
                               mmem[21'h205] : 8'h00), 32'h45);

      // reset release timing and completion pulse
      if (la.size() == 6) begin
         chk("t5_cr_fall", 32'(cr_fall - lc[5]), 19);
         chk("t5_done_cyc", 32'(done_cyc), 32'(cr_fall));
      end
      chk("t5_done_cnt", 32'(done_cnt), 1);

      // core passthrough write
      log_en = 0;
      core_a = 21'h00123; core_dout = 8'h5A; core_we_n = 0;
      sram_din = 8'hC3;
      @(negedge clk);
      chk("t5_pass_a", 32'(SRAM_A), 32'h00123);
      chk("t5_pass_d", 32'(sram_dout), 32'h5A);
      chk("t5_pass_we", 32'(SRAM_WE_n), 0);
      chk("t5_pass_oe", 32'(sram_d_oe), 1);
      chk("t5_core_din", 32'(core_din), 32'hC3);
      tick();
      core_we_n = 1; log_en = 1;
      tick();

      // unsupported index is ignored
      clr(); ioctl_download = 1; tick();
      for (int i = 0; i < 6; i++) begin
         send(8'h02, 25'(i), 8'h60 + 8'(i));
         chk($sformatf("t4_wait%0d", i), 32'(ioctl_wait), 0);
      end
      ioctl_download = 0; r = cyc;
      repeat (30) tick();
      chk("t4_no_writes", 32'(la.size()), 0);
      chk("t4_no_done", 32'(done_cnt), 0);
      chk("t4_cr_fall", 32'(cr_fall - r), 16);

      // reset during the WE pulse
      ioctl_download = 1; tick();
      send(8'h01, 25'h300, 8'hE1);
      send(8'h01, 25'h301, 8'hE2);
      tick();
      chk("t6_we_low", 32'(SRAM_WE_n), 0);
      #1 rst_n = 0; ioctl_download = 0;
      #1 chk("t6_we_async", 32'(SRAM_WE_n), 1);
      clr();
      tick(); tick();
      rst_n = 1; r = cyc;
      chk("t6_core_reset", 32'(core_reset), 1);
      repeat (30) tick();
      chk("t6_flushed", 32'(la.size()), 0);
      chk("t6_cr_fall", 32'(cr_fall - r), 16);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
